// File: rtl/sim_run_sequencer_if.sv
// Host/DUT signal bundle of the simulation run sequencer: the finish and soft-reset requests
// from the cycle hook, and the reset, status and cycle-count outputs.
interface sim_run_sequencer_if;
    logic        finish_req;
    logic        soft_reset_req;
    logic        main_rst_o;
    logic        derived_rst_o;
    logic        running_o;
    logic        finish_o;
    logic        timeout_o;
    logic [31:0] cycle_count;
    logic [2:0]  state_o;

    modport master (
        output finish_req, soft_reset_req,
        input  main_rst_o, derived_rst_o, running_o, finish_o, timeout_o, cycle_count, state_o
    );

    modport slave (
        input  finish_req, soft_reset_req,
        output main_rst_o, derived_rst_o, running_o, finish_o, timeout_o, cycle_count, state_o
    );
endinterface

// File: rtl/sim_run_sequencer.sv
// Run controller for the simulation top: staged reset release, cycle counting,
// drained sticky finish and a watchdog cycle limit.
module sim_run_sequencer #(
    parameter int unsigned RESET_CYCLES  = 20,
    parameter int unsigned DERIVED_DELAY = 0,
    parameter int unsigned DRAIN_CYCLES  = 4,
    parameter int unsigned MAX_CYCLES    = 0
) (
    input logic               CLK,
    input logic               RST,
    sim_run_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        ST_HOLD  = 3'd0,
        ST_DWAIT = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_DONE  = 3'd4
    } state_t;

    // hold_cnt is shared by HOLD and DWAIT, so it is sized for the larger of the two limits
    localparam int unsigned HOLD_LIM = (RESET_CYCLES > DERIVED_DELAY) ? RESET_CYCLES : DERIVED_DELAY;
    localparam int unsigned HOLD_W   = $clog2(HOLD_LIM) + 1;
    localparam int unsigned DRAIN_W  = $clog2(DRAIN_CYCLES) + 1;

    localparam logic [HOLD_W-1:0]  HOLD_LAST  = HOLD_W'(RESET_CYCLES - 1);
    localparam logic [HOLD_W-1:0]  DWAIT_LAST = (DERIVED_DELAY == 0) ? '0 : HOLD_W'(DERIVED_DELAY - 1);
    localparam logic [DRAIN_W-1:0] DRAIN_LAST = DRAIN_W'(DRAIN_CYCLES - 1);

    state_t             state_r, state_s;
    logic [HOLD_W-1:0]  hold_cnt_r, hold_cnt_s;
    logic [DRAIN_W-1:0] drain_cnt_r, drain_cnt_s;
    logic [31:0]        cycle_count_r, cycle_next_s;
    logic               main_rst_r, main_rst_s;
    logic               derived_rst_r, derived_rst_s;
    logic               running_r, running_s;
    logic               finish_r, finish_s;
    logic               timeout_r, timeout_s;
    logic               wdog_s;
    logic               soft_ok_s;

    // Saturating cycle counter next value and the watchdog / soft-reset qualifiers
    always_comb begin
        if (cycle_count_r == 32'hFFFF_FFFF) begin
            cycle_next_s = cycle_count_r;
        end else begin
            cycle_next_s = cycle_count_r + 32'd1;
        end
        wdog_s    = (MAX_CYCLES != 32'd0) && (state_r != ST_DONE) && (cycle_next_s == 32'(MAX_CYCLES));
        soft_ok_s = bus.soft_reset_req && ((state_r == ST_RUN) || (state_r == ST_DRAIN));
    end

    // Next-state and next-output logic; watchdog beats soft reset beats finish beats counting
    always_comb begin
        state_s       = state_r;
        hold_cnt_s    = hold_cnt_r;
        drain_cnt_s   = drain_cnt_r;
        main_rst_s    = main_rst_r;
        derived_rst_s = derived_rst_r;
        running_s     = running_r;
        finish_s      = finish_r;
        timeout_s     = timeout_r;
        if (wdog_s) begin
            state_s       = ST_DONE;
            finish_s      = 1'b1;
            timeout_s     = 1'b1;
            main_rst_s    = 1'b0;
            derived_rst_s = 1'b0;
            running_s     = 1'b0;
        end else if (soft_ok_s) begin
            state_s       = ST_HOLD;
            main_rst_s    = 1'b1;
            derived_rst_s = 1'b1;
            running_s     = 1'b0;
            hold_cnt_s    = '0;
            drain_cnt_s   = '0;
        end else begin
            case (state_r)
                ST_HOLD: begin
                    if (hold_cnt_r == HOLD_LAST) begin
                        hold_cnt_s = '0;
                        main_rst_s = 1'b0;
                        if (DERIVED_DELAY == 0) begin
                            derived_rst_s = 1'b0;
                            running_s     = 1'b1;
                            state_s       = ST_RUN;
                        end else begin
                            state_s = ST_DWAIT;
                        end
                    end else begin
                        hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                    end
                end
                ST_DWAIT: begin
                    if (hold_cnt_r == DWAIT_LAST) begin
                        hold_cnt_s    = '0;
                        derived_rst_s = 1'b0;
                        running_s     = 1'b1;
                        state_s       = ST_RUN;
                    end else begin
                        hold_cnt_s = hold_cnt_r + HOLD_W'(1);
                    end
                end
                ST_RUN: begin
                    if (bus.finish_req) begin
                        state_s     = ST_DRAIN;
                        drain_cnt_s = '0;
                        running_s   = 1'b0;
                    end else begin
                        state_s = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (drain_cnt_r == DRAIN_LAST) begin
                        state_s  = ST_DONE;
                        finish_s = 1'b1;
                    end else begin
                        drain_cnt_s = drain_cnt_r + DRAIN_W'(1);
                    end
                end
                ST_DONE: begin
                    state_s = ST_DONE;
                end
                default: begin
                    state_s       = ST_HOLD;
                    hold_cnt_s    = '0;
                    drain_cnt_s   = '0;
                    main_rst_s    = 1'b1;
                    derived_rst_s = 1'b1;
                    running_s     = 1'b0;
                end
            endcase
        end
    end

    // State, counter and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_r       <= ST_HOLD;
            hold_cnt_r    <= '0;
            drain_cnt_r   <= '0;
            cycle_count_r <= 32'd0;
            main_rst_r    <= 1'b1;
            derived_rst_r <= 1'b1;
            running_r     <= 1'b0;
            finish_r      <= 1'b0;
            timeout_r     <= 1'b0;
        end else begin
            state_r       <= state_s;
            hold_cnt_r    <= hold_cnt_s;
            drain_cnt_r   <= drain_cnt_s;
            cycle_count_r <= cycle_next_s;
            main_rst_r    <= main_rst_s;
            derived_rst_r <= derived_rst_s;
            running_r     <= running_s;
            finish_r      <= finish_s;
            timeout_r     <= timeout_s;
        end
    end

    assign bus.main_rst_o    = main_rst_r;
    assign bus.derived_rst_o = derived_rst_r;
    assign bus.running_o     = running_r;
    assign bus.finish_o      = finish_r;
    assign bus.timeout_o     = timeout_r;
    assign bus.cycle_count   = cycle_count_r;
    assign bus.state_o       = state_r;
endmodule

// File: tb/tb_sim_run_sequencer.sv
// Scoreboard bench: three sequencer instances (defaults, DERIVED_DELAY=5, MAX_CYCLES=50)
// with expected output snapshots queued per clock edge and compared at the following negedge.
module tb_sim_run_sequencer;
    logic CLK = 1'b0;
    logic rst0, rst1, rst2;
    int   edge_n   = 0;
    int   checks_n = 0;
    int   errors_n = 0;

    typedef struct {
        int          e;
        int          d;
        logic [39:0] v;
    } exp_t;

    exp_t sb_q[$];
    exp_t mon_item;

    sim_run_sequencer_if if0();
    sim_run_sequencer_if if1();
    sim_run_sequencer_if if2();

    sim_run_sequencer dut0 (.CLK(CLK), .RST(rst0), .bus(if0));
    sim_run_sequencer #(.DERIVED_DELAY(5)) dut1 (.CLK(CLK), .RST(rst1), .bus(if1));
    sim_run_sequencer #(.MAX_CYCLES(50)) dut2 (.CLK(CLK), .RST(rst2), .bus(if2));

    always #5 CLK = ~CLK;

    always @(posedge CLK) edge_n <= edge_n + 1;

    task automatic check_val(input string tag, input logic [39:0] obs, input logic [39:0] exp);
        checks_n++;
        if (obs !== exp) begin
            errors_n++;
            $display("FAIL %s: got main=%b der=%b run=%b fin=%b to=%b st=%0d cc=%0d, expected main=%b der=%b run=%b fin=%b to=%b st=%0d cc=%0d",
                     tag, obs[39], obs[38], obs[37], obs[36], obs[35], obs[34:32], obs[31:0],
                     exp[39], exp[38], exp[37], exp[36], exp[35], exp[34:32], exp[31:0]);
        end
    endtask

    function automatic logic [39:0] get_obs(input int d);
        case (d)
            0:       return {if0.main_rst_o, if0.derived_rst_o, if0.running_o, if0.finish_o,
                             if0.timeout_o, if0.state_o, if0.cycle_count};
            1:       return {if1.main_rst_o, if1.derived_rst_o, if1.running_o, if1.finish_o,
                             if1.timeout_o, if1.state_o, if1.cycle_count};
            default: return {if2.main_rst_o, if2.derived_rst_o, if2.running_o, if2.finish_o,
                             if2.timeout_o, if2.state_o, if2.cycle_count};
        endcase
    endfunction

    // Queue an expected snapshot for instance d after absolute edge e, kept in edge order
    task automatic expect_at(input int d, input int e, input logic mr, input logic dr, input logic rn,
                             input logic fn, input logic to, input logic [2:0] st, input int cc);
        exp_t item;
        int   pos;
        item.e = e;
        item.d = d;
        item.v = {mr, dr, rn, fn, to, st, 32'(cc)};
        pos = sb_q.size();
        for (int i = 0; i < sb_q.size(); i++) begin
            if (sb_q[i].e > e) begin
                pos = i;
                break;
            end
        end
        sb_q.insert(pos, item);
    endtask

    task automatic wait_edge(input int e);
        while (edge_n < e) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Compare every snapshot due at the edge just taken
    always @(negedge CLK) begin
        while (sb_q.size() > 0 && sb_q[0].e <= edge_n) begin
            mon_item = sb_q.pop_front();
            check_val($sformatf("d%0d@e%0d", mon_item.d, mon_item.e), get_obs(mon_item.d), mon_item.v);
        end
    end

    localparam int B = 3;
    localparam int R = B + 137;

    initial begin
        rst0 = 1'b1; rst1 = 1'b1; rst2 = 1'b1;
        if0.finish_req = 1'b0; if0.soft_reset_req = 1'b0;
        if1.finish_req = 1'b0; if1.soft_reset_req = 1'b0;
        if2.finish_req = 1'b0; if2.soft_reset_req = 1'b0;
        wait_edge(B);

        // defaults: reset release, then a one-cycle finish pulse drained into DONE
        expect_at(0, B,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0);
        expect_at(0, B + 19,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 19);
        expect_at(0, B + 20,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 20);
        expect_at(0, B + 27,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 27);
        expect_at(0, B + 28,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 28);
        expect_at(0, B + 31,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 31);
        expect_at(0, B + 32,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 32);
        expect_at(0, B + 132, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 3'd4, 132);
        // derived delay of 5, then soft reset while drain_cnt is 2
        expect_at(1, B,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0);
        expect_at(1, B + 20,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 20);
        expect_at(1, B + 24,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 24);
        expect_at(1, B + 25,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 25);
        expect_at(1, B + 31,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 31);
        expect_at(1, B + 33,  1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 33);
        expect_at(1, B + 34,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 34);
        expect_at(1, B + 38,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 38);
        expect_at(1, B + 53,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 53);
        expect_at(1, B + 54,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 54);
        expect_at(1, B + 58,  1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd1, 58);
        expect_at(1, B + 59,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 59);
        // watchdog at 50 overriding simultaneous finish and soft-reset requests
        expect_at(2, B,       1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0);
        expect_at(2, B + 20,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 20);
        expect_at(2, B + 49,  1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 49);
        expect_at(2, B + 50,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 50);
        expect_at(2, B + 60,  1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 3'd4, 60);
        rst0 = 1'b0; rst1 = 1'b0; rst2 = 1'b0;

        wait_edge(B + 27); if0.finish_req = 1'b1;
        wait_edge(B + 28); if0.finish_req = 1'b0;
        wait_edge(B + 30); if1.finish_req = 1'b1;
        wait_edge(B + 31); if1.finish_req = 1'b0;
        wait_edge(B + 33); if1.soft_reset_req = 1'b1;
        wait_edge(B + 34); if1.soft_reset_req = 1'b0;
        wait_edge(B + 49); if2.finish_req = 1'b1; if2.soft_reset_req = 1'b1;
        wait_edge(B + 50); if2.finish_req = 1'b0; if2.soft_reset_req = 1'b0;

        // finish_req held through reset, then RST in the middle of DRAIN
        wait_edge(B + 135); rst0 = 1'b1; if0.finish_req = 1'b1;
        wait_edge(R);
        expect_at(0, R,      1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0);
        expect_at(0, R + 19, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 19);
        expect_at(0, R + 20, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd2, 20);
        expect_at(0, R + 21, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 21);
        expect_at(0, R + 22, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3, 22);
        expect_at(0, R + 23, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0, 0);
        rst0 = 1'b0;
        wait_edge(R + 22); rst0 = 1'b1;
        wait_edge(R + 23); rst0 = 1'b0; if0.finish_req = 1'b0;

        wait_edge(R + 26);
        check_val("scoreboard_drained", 40'(sb_q.size()), 40'd0);
        $display("Result: errors=%0d of %0d checks", errors_n, checks_n);
        $finish;
    end
endmodule
